// File: rtl/snake_pkg.sv
// Shared definitions for the snake direction front end: direction encoding,
// default IR command codes and the opposite-direction helper.
package snake_pkg;

  localparam logic [1:0] DIR_UP    = 2'd0;
  localparam logic [1:0] DIR_DOWN  = 2'd1;
  localparam logic [1:0] DIR_LEFT  = 2'd2;
  localparam logic [1:0] DIR_RIGHT = 2'd3;

  localparam logic [7:0] IR_UP_DEF    = 8'h18;
  localparam logic [7:0] IR_DOWN_DEF  = 8'h52;
  localparam logic [7:0] IR_LEFT_DEF  = 8'h08;
  localparam logic [7:0] IR_RIGHT_DEF = 8'h5A;

  // Up/down and left/right share bit 1 and differ in bit 0.
  function automatic logic [1:0] dir_opposite(input logic [1:0] d);
    return {d[1], ~d[0]};
  endfunction

endpackage

// File: rtl/key_debounce_ch.sv
// One key channel: 2-flop synchroniser, stability counter and a one-cycle
// pulse on each accepted released->pressed transition.
module key_debounce_ch #(
  parameter int DEB_CYCLES     = 250000,
  parameter bit KEY_ACTIVE_LOW = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic key_raw,
  output logic press
);

  localparam int CNT_W = (DEB_CYCLES > 2) ? $clog2(DEB_CYCLES) : 1;

  logic             sync_p0;
  logic             sync_p1;
  logic             deb_lvl;
  logic [CNT_W-1:0] cnt;
  logic             lvl_s;
  logic             cnt_done;

  assign lvl_s    = sync_p1 ^ KEY_ACTIVE_LOW;
  assign cnt_done = (cnt == CNT_W'(DEB_CYCLES - 1));

  // Synchroniser flops reset to the released pin level so reset is not a press.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_p0 <= KEY_ACTIVE_LOW;
      sync_p1 <= KEY_ACTIVE_LOW;
    end else begin
      sync_p0 <= key_raw;
      sync_p1 <= sync_p0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      deb_lvl <= 1'b0;
      cnt     <= '0;
      press   <= 1'b0;
    end else begin
      press <= 1'b0;
      if (lvl_s == deb_lvl) begin
        cnt <= '0;
      end else if (cnt_done) begin
        deb_lvl <= lvl_s;
        cnt     <= '0;
        press   <= lvl_s;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/snake_dir_ctrl.sv
// Snake direction front end: debounced keys and IR codes merged into one
// direction stream, reversal filtering and a step-drained turn queue.
module snake_dir_ctrl
  import snake_pkg::*;
#(
  parameter int         NUM_KEYS       = 4,
  parameter int         DEB_CYCLES     = 250000,
  parameter int         Q_DEPTH        = 4,
  parameter bit         KEY_ACTIVE_LOW = 1'b1,
  parameter logic [7:0] IR_UP          = IR_UP_DEF,
  parameter logic [7:0] IR_DOWN        = IR_DOWN_DEF,
  parameter logic [7:0] IR_LEFT        = IR_LEFT_DEF,
  parameter logic [7:0] IR_RIGHT       = IR_RIGHT_DEF
) (
  input  logic                                    sys_clk,
  input  logic                                    sys_rst,
  input  logic [NUM_KEYS-1:0]                     key_in,
  input  logic                                    ir_data_en,
  input  logic [7:0]                              ir_data,
  input  logic                                    ir_repeat_en,
  input  logic                                    step,
  output logic [1:0]                              dir_out,
  output logic                                    dir_valid,
  output logic [((NUM_KEYS > 4) ? NUM_KEYS-4 : 1)-1:0] aux_pulse,
  output logic [$clog2(Q_DEPTH):0]                q_level,
  output logic                                    q_overflow
);

  localparam int PTR_W = $clog2(Q_DEPTH);

  logic [NUM_KEYS-1:0] press_p0;
  logic                unused_ir_repeat;

  assign unused_ir_repeat = ir_repeat_en;

  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
    key_debounce_ch #(
      .DEB_CYCLES    (DEB_CYCLES),
      .KEY_ACTIVE_LOW(KEY_ACTIVE_LOW)
    ) u_deb (
      .clk    (sys_clk),
      .rst    (sys_rst),
      .key_raw(key_in[i]),
      .press  (press_p0[i])
    );
  end

  if (NUM_KEYS > 4) begin : g_aux
    assign aux_pulse = press_p0[NUM_KEYS-1:4];
  end else begin : g_no_aux
    assign aux_pulse = '0;
  end

  // Stage p0: candidate selection; keys override IR, lowest channel wins.
  logic       cand_vld;
  logic [1:0] cand_dir;

  always_comb begin
    cand_vld = 1'b0;
    cand_dir = DIR_UP;
    if (ir_data_en) begin
      if (ir_data == IR_UP) begin
        cand_vld = 1'b1;
        cand_dir = DIR_UP;
      end else if (ir_data == IR_DOWN) begin
        cand_vld = 1'b1;
        cand_dir = DIR_DOWN;
      end else if (ir_data == IR_LEFT) begin
        cand_vld = 1'b1;
        cand_dir = DIR_LEFT;
      end else if (ir_data == IR_RIGHT) begin
        cand_vld = 1'b1;
        cand_dir = DIR_RIGHT;
      end
    end
    for (int i = 3; i >= 0; i--) begin
      if (press_p0[i]) begin
        cand_vld = 1'b1;
        cand_dir = 2'(i);
      end
    end
  end

  logic [1:0]       q_mem [Q_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] last_ptr;
  logic [1:0]       ref_dir;
  logic             accept;
  logic             q_full;
  logic             pop;
  logic             push;
  logic             drop;

  assign last_ptr = wr_ptr - 1'b1;
  assign ref_dir  = (q_level != '0) ? q_mem[last_ptr] : dir_out;
  assign accept   = cand_vld && (cand_dir != ref_dir) &&
                    (cand_dir != dir_opposite(ref_dir));
  assign q_full   = (q_level == ($clog2(Q_DEPTH)+1)'(Q_DEPTH));
  assign pop      = step && (q_level != '0);
  assign push     = accept && (!q_full || pop);
  assign drop     = accept && q_full && !pop;

  // Stage p1: queue storage, pointers and released direction.
  always_ff @(posedge sys_clk) begin
    if (push) q_mem[wr_ptr] <= cand_dir;
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      q_level    <= '0;
      dir_out    <= DIR_RIGHT;
      dir_valid  <= 1'b0;
      q_overflow <= 1'b0;
    end else begin
      dir_valid <= pop;
      if (pop) begin
        dir_out <= q_mem[rd_ptr];
        rd_ptr  <= rd_ptr + 1'b1;
      end
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (push && !pop)      q_level <= q_level + 1'b1;
      else if (pop && !push) q_level <= q_level - 1'b1;
      if (drop) q_overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_snake_dir_ctrl.sv
// Bench for snake_dir_ctrl: key/IR corner sequences, a direction vector
// table and a randomized IR/step run against a queue-based reference.
module tb_snake_dir_ctrl;

  localparam int NK  = 5;
  localparam int DEB = 8;
  localparam int QD  = 4;

  logic          sys_clk = 1'b0;
  logic          sys_rst;
  logic [NK-1:0] key_in;
  logic          ir_data_en;
  logic [7:0]    ir_data;
  logic          ir_repeat_en;
  logic          step;
  logic [1:0]    dir_out;
  logic          dir_valid;
  logic [0:0]    aux_pulse;
  logic [2:0]    q_level;
  logic          q_overflow;

  int n_pass = 0;
  int n_total = 0;

  snake_dir_ctrl #(
    .NUM_KEYS(NK), .DEB_CYCLES(DEB), .Q_DEPTH(QD), .KEY_ACTIVE_LOW(1'b1)
  ) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .key_in(key_in),
    .ir_data_en(ir_data_en), .ir_data(ir_data), .ir_repeat_en(ir_repeat_en),
    .step(step), .dir_out(dir_out), .dir_valid(dir_valid),
    .aux_pulse(aux_pulse), .q_level(q_level), .q_overflow(q_overflow)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct {
    bit         en;
    logic [7:0] code;
    bit         rep;
    bit         stp;
    int         dir;
    bit         vld;
    int         lvl;
    bit         ovf;
  } vec_t;

  vec_t tbl [22];

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic cycle();
    @(posedge sys_clk);
    @(negedge sys_clk);
  endtask

  task automatic do_reset();
    sys_rst = 1'b1;
    cycle();
    cycle();
    sys_rst = 1'b0;
    cycle();
  endtask

  function automatic vec_t mk(bit en, logic [7:0] code, bit rep, bit stp,
                              int dir, bit vld, int lvl, bit ovf);
    vec_t v;
    v.en = en; v.code = code; v.rep = rep; v.stp = stp;
    v.dir = dir; v.vld = vld; v.lvl = lvl; v.ovf = ovf;
    return v;
  endfunction

  // Reference decode of IR command codes; -1 means no direction.
  function automatic int ir_to_dir(logic [7:0] c);
    case (c)
      8'h18:   return 0;
      8'h52:   return 1;
      8'h08:   return 2;
      8'h5A:   return 3;
      default: return -1;
    endcase
  endfunction

  function automatic int opp(int d);
    case (d)
      0: return 1;
      1: return 0;
      2: return 3;
      default: return 2;
    endcase
  endfunction

  int n_lat;
  int cnt;
  int mdir;
  bit movf;
  int mq[$];

  initial begin
    sys_rst = 1'b1;
    key_in = '1;
    ir_data_en = 1'b0;
    ir_data = 8'h00;
    ir_repeat_en = 1'b0;
    step = 1'b0;

    tbl[0]  = mk(1, 8'h08, 0, 0, 3, 0, 0, 0);
    tbl[1]  = mk(1, 8'h5A, 0, 0, 3, 0, 0, 0);
    tbl[2]  = mk(1, 8'h18, 0, 0, 3, 0, 1, 0);
    tbl[3]  = mk(1, 8'h08, 0, 0, 3, 0, 2, 0);
    tbl[4]  = mk(0, 8'h00, 0, 1, 0, 1, 1, 0);
    tbl[5]  = mk(0, 8'h00, 0, 1, 2, 1, 0, 0);
    tbl[6]  = mk(0, 8'h00, 0, 1, 2, 0, 0, 0);
    tbl[7]  = mk(1, 8'h33, 0, 0, 2, 0, 0, 0);
    tbl[8]  = mk(1, 8'h52, 0, 0, 2, 0, 1, 0);
    tbl[9]  = mk(1, 8'h08, 0, 0, 2, 0, 2, 0);
    tbl[10] = mk(1, 8'h18, 0, 0, 2, 0, 3, 0);
    tbl[11] = mk(1, 8'h08, 0, 0, 2, 0, 4, 0);
    tbl[12] = mk(1, 8'h18, 0, 0, 2, 0, 4, 1);
    tbl[13] = mk(1, 8'h18, 0, 1, 1, 1, 4, 1);
    tbl[14] = mk(0, 8'h00, 0, 1, 2, 1, 3, 1);
    tbl[15] = mk(0, 8'h00, 0, 1, 0, 1, 2, 1);
    tbl[16] = mk(0, 8'h00, 0, 1, 2, 1, 1, 1);
    tbl[17] = mk(0, 8'h00, 0, 1, 0, 1, 0, 1);
    tbl[18] = mk(0, 8'h00, 0, 1, 0, 0, 0, 1);
    tbl[19] = mk(1, 8'h08, 0, 1, 0, 0, 1, 1);
    tbl[20] = mk(0, 8'h00, 0, 1, 2, 1, 0, 1);
    tbl[21] = mk(0, 8'h18, 1, 0, 2, 0, 0, 1);

    cycle();
    cycle();
    chk("reset_dir", dir_out, 3);
    chk("reset_valid", dir_valid, 0);
    chk("reset_level", q_level, 0);
    chk("reset_ovf", q_overflow, 0);
    chk("reset_aux", aux_pulse, 0);
    sys_rst = 1'b0;
    cycle();

    // Idle with periodic steps.
    cnt = 0;
    for (int i = 0; i < 100; i++) begin
      step = (i % 20 == 19);
      cycle();
      step = 1'b0;
      if (dir_valid) cnt++;
    end
    chk("idle_valid_count", cnt, 0);
    chk("idle_dir", dir_out, 3);
    chk("idle_level", q_level, 0);

    // Glitch shorter than the debounce window.
    key_in[0] = 1'b0;
    repeat (4) cycle();
    key_in[0] = 1'b1;
    repeat (20) cycle();
    chk("glitch_level", q_level, 0);

    // Clean press on up: measure latency to enqueue.
    key_in[0] = 1'b0;
    n_lat = 0;
    for (int i = 1; i <= 30; i++) begin
      cycle();
      if (q_level == 3'd1) begin
        n_lat = i;
        break;
      end
    end
    n_total++;
    if (n_lat >= DEB + 2 && n_lat <= DEB + 4) n_pass++;
    else $display("FAIL press_latency: got %0d cycles, expected %0d..%0d", n_lat, DEB + 2, DEB + 4);
    repeat (20) cycle();
    key_in[0] = 1'b1;
    repeat (20) cycle();
    chk("press_level_held", q_level, 1);
    step = 1'b1;
    cycle();
    step = 1'b0;
    chk("press_step_dir", dir_out, 0);
    chk("press_step_valid", dir_valid, 1);
    chk("press_step_level", q_level, 0);
    cycle();
    chk("press_valid_one_cycle", dir_valid, 0);

    // Key up and IR down arriving in the same cycle.
    do_reset();
    if (n_lat < 2) n_lat = DEB + 3;
    key_in[0] = 1'b0;
    repeat (n_lat - 1) cycle();
    ir_data_en = 1'b1;
    ir_data = 8'h52;
    cycle();
    ir_data_en = 1'b0;
    chk("collide_level", q_level, 1);
    step = 1'b1;
    cycle();
    step = 1'b0;
    chk("collide_dir", dir_out, 0);
    key_in[0] = 1'b1;
    repeat (20) cycle();
    chk("collide_level_after", q_level, 0);

    // Vector table of IR/step transactions.
    do_reset();
    foreach (tbl[i]) begin
      ir_data_en = tbl[i].en;
      ir_data = tbl[i].code;
      ir_repeat_en = tbl[i].rep;
      step = tbl[i].stp;
      cycle();
      ir_data_en = 1'b0;
      ir_repeat_en = 1'b0;
      step = 1'b0;
      chk($sformatf("tbl%0d_dir", i), dir_out, tbl[i].dir);
      chk($sformatf("tbl%0d_valid", i), dir_valid, tbl[i].vld);
      chk($sformatf("tbl%0d_level", i), q_level, tbl[i].lvl);
      chk($sformatf("tbl%0d_ovf", i), q_overflow, tbl[i].ovf);
    end

    // Asynchronous reset in the middle of a debounce.
    key_in[1] = 1'b0;
    repeat (5) cycle();
    #2 sys_rst = 1'b1;
    #1;
    chk("async_rst_dir", dir_out, 3);
    chk("async_rst_valid", dir_valid, 0);
    chk("async_rst_level", q_level, 0);
    chk("async_rst_ovf", q_overflow, 0);
    chk("async_rst_aux", aux_pulse, 0);
    key_in[1] = 1'b1;
    cycle();
    cycle();
    sys_rst = 1'b0;
    repeat (20) cycle();
    chk("async_rst_no_push", q_level, 0);

    // Auxiliary key press.
    key_in[4] = 1'b0;
    cnt = 0;
    for (int i = 0; i < 30; i++) begin
      cycle();
      if (aux_pulse[0]) cnt++;
    end
    chk("aux_pulse_count", cnt, 1);
    chk("aux_level", q_level, 0);
    key_in[4] = 1'b1;
    repeat (20) cycle();

    // Randomized IR/step traffic against a queue reference.
    mdir = 3;
    movf = 1'b0;
    mq.delete();
    for (int i = 0; i < 400; i++) begin
      int sel;
      int cand;
      int refd;
      int n;
      bit popping;
      sel = $urandom_range(0, 4);
      ir_data_en = $urandom_range(0, 1);
      case (sel)
        0: ir_data = 8'h18;
        1: ir_data = 8'h52;
        2: ir_data = 8'h08;
        3: ir_data = 8'h5A;
        default: ir_data = 8'($urandom_range(0, 255));
      endcase
      ir_repeat_en = $urandom_range(0, 1);
      step = ($urandom_range(0, 3) == 0);

      cand = ir_data_en ? ir_to_dir(ir_data) : -1;
      n = mq.size();
      refd = (n > 0) ? mq[n-1] : mdir;
      popping = step && (n > 0);
      if (popping) mdir = mq.pop_front();
      if (cand >= 0 && cand != refd && cand != opp(refd)) begin
        if (n == QD && !popping) movf = 1'b1;
        else mq.push_back(cand);
      end

      cycle();
      ir_data_en = 1'b0;
      ir_repeat_en = 1'b0;
      step = 1'b0;
      chk($sformatf("rnd%0d_dir", i), dir_out, mdir);
      chk($sformatf("rnd%0d_valid", i), dir_valid, popping);
      chk($sformatf("rnd%0d_level", i), q_level, mq.size());
      chk($sformatf("rnd%0d_ovf", i), q_overflow, movf);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/snake_dir_ctrl.md
Name: snake_dir_ctrl

Overview:
Parametrised direction-input front end for the snake game, replacing the four separate per-key debouncers and the direct IR-code path into the display logic. It debounces NUM_KEYS key channels, decodes IR direction codes, and merges both sources into one direction stream. Invalid reversals are rejected and accepted turns are buffered in a small queue, so quick double-turns between game ticks are not lost. One direction is released per game step; extra keys come out as auxiliary press pulses (pause/start).

Parameters:
NUM_KEYS, 4, key channels; ch0..3 = up, down, left, right; ch4..NUM_KEYS-1 auxiliary (range 4..8)
DEB_CYCLES, 250000, stable cycles required to accept a level change (10 ms at 25 MHz); >=2
Q_DEPTH, 4, direction queue depth; power of two, 2..16
KEY_ACTIVE_LOW, 1, 1 = key pressed when pin low
IR_UP, 8'h18, IR command code for up
IR_DOWN, 8'h52, IR command code for down
IR_LEFT, 8'h08, IR command code for left
IR_RIGHT, 8'h5A, IR command code for right

Ports:
sys_clk  in  1  game clock (25 MHz VGA clock)
sys_rst  in  1  asynchronous reset, active-high
key_in  in  NUM_KEYS  raw key pins, asynchronous
ir_data_en  in  1  one-cycle strobe: ir_data valid (already in sys_clk domain)
ir_data  in  8  IR command code
ir_repeat_en  in  1  IR repeat strobe; ignored
step  in  1  one-cycle game-tick pulse; consumes one queued direction
dir_out  out  2  current direction: 0 up, 1 down, 2 left, 3 right
dir_valid  out  1  one-cycle pulse when dir_out is updated from the queue
aux_pulse  out  max(NUM_KEYS-4,1)  one-cycle press pulse per aux key; bit 0 tied 0 when NUM_KEYS=4
q_level  out  $clog2(Q_DEPTH)+1  queue occupancy
q_overflow  out  1  sticky: a valid direction was dropped because the queue was full

Behaviour:
- Reset (async assert; release is synchronous in effect): dir_out=3 (right), dir_valid=0, aux_pulse=0, q_level=0, q_overflow=0, all debounced levels = released, counters=0.
- Per channel: 2-flop synchroniser, then a debounce counter. The counter runs while the synchronised level differs from the debounced level and clears when they match. When the counter reaches DEB_CYCLES-1, the debounced level toggles.
- Only a released->pressed toggle generates a press pulse, in the cycle after the toggle. Release generates nothing.
- Latency: a clean press stable from cycle 0 gives its press pulse at cycle 2+DEB_CYCLES+1 (within ±1). The bench checks it inside the window [DEB_CYCLES+2, DEB_CYCLES+4].
- Glitches shorter than DEB_CYCLES produce no pulse.
- IR: ir_data_en with ir_data equal to one of the IR_* codes gives a direction candidate in the same cycle. Unmatched codes and ir_repeat_en are ignored.
- Arbitration in one cycle: key candidates beat the IR candidate; among keys, the lowest channel index wins. Losers are discarded silently. At most one candidate per cycle.
- Reference direction = the last enqueued direction if q_level>0, else dir_out.
- A candidate is rejected if it equals the reference or is its opposite. Opposites are decided by bit1 equal and bit0 different.
- Accepted candidate with queue full: dropped and q_overflow set; it stays set until reset.
- Otherwise the candidate is pushed (circular buffer, wrap-around pointers).
- step with q_level>0: pop the head; dir_out takes it on the next edge; dir_valid=1 for that one cycle.
- step with empty queue: dir_out held, dir_valid=0.
- Push and step in the same cycle: both take effect and q_level is unchanged. The push is checked against the pre-pop reference. With a full queue, a push plus step is accepted (no overflow).
- Push into an empty queue plus step in the same cycle: the pop is not served this cycle; the entry pops on the next step.
- Aux channels: press pulse drives aux_pulse[ch-4] for one cycle; no queueing.

Decomposition:
- Shared package snake_pkg: direction encoding constants DIR_UP/DOWN/LEFT/RIGHT, an opposite-direction function, default IR codes.
- One sub-module key_debounce_ch (synchroniser + counter + press pulse), instantiated NUM_KEYS times by generate.
- Queue and arbitration stay in the top of this block.

Test Plan:
(DEB_CYCLES=8, Q_DEPTH=4 for simulation)
- Reset, idle, step every 20 cycles -> dir_out=3, dir_valid never asserts, q_level=0.
- key_in[0] low for 4 cycles then high -> no push, q_level=0. Then key_in[0] low for 20 cycles -> q_level=1 within 12 cycles. Next step -> dir_out=0, dir_valid one cycle.
- dir_out=3, IR 8'h08 (left) -> rejected (q_level stays 0). IR 8'h18 then 8'h08, then two steps -> dir_out sequence 0, then 2.
- Key up and ir_data_en with 8'h52 in the same cycle -> only up enqueued, q_level=1.
- Push 5 alternating valid turns without step -> q_level=4, q_overflow=1. Then apply 4 steps -> the first 4 directions come out in order, and q_overflow stays 1.
- NUM_KEYS=5, press key_in[4] -> aux_pulse[0] high exactly one cycle, q_level unchanged. Assert sys_rst mid-debounce -> all outputs return to reset values immediately.
